// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared types and constants for the stochastic-symbol decoder
//
// Contents:
//   ss_state_t  measurement FSM states (IDLE, WARM, ACC, HOLD)
//   SS_SYM_W    width of one stochastic symbol
//   SS_SYM_MAX  largest legal symbol value; anything above is flagged
//   MEAN_FRAC   fractional bits of the reported mean (Q2.6)
//   ss_cnt_w()  width of a counter that must reach a given count, min 1

package ss_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    ACC  = 2'd2,
    HOLD = 2'd3
  } ss_state_t;

  localparam int SS_SYM_W   = 2;
  localparam int SS_SYM_MAX = 2;
  localparam int MEAN_FRAC  = 6;

  // Bits needed to hold values 0..max_count; a zero-length counter is
  // still given one bit so it can be declared.
  function automatic int ss_cnt_w(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ss_window_accumulator.sv
// rtl/ss_window_accumulator.sv - sums one window of stochastic symbols
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   clear     in   zero sum, window counter and error flag
//   enable    in   one valid window symbol this cycle
//   sym       in   symbol value (0..2 legal, 3 counted and flagged)
//   sum_next  out  running sum including this cycle's symbol
//   err_next  out  error flag including this cycle's symbol
//   last      out  this enabled symbol completes the window

module ss_window_accumulator
  import ss_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int SUM_W    = WIN_LOG2 + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [SS_SYM_W-1:0] sym,
  output logic [SUM_W-1:0]    sum_next,
  output logic                err_next,
  output logic                last
);

  localparam int                       CNT_W    = ss_cnt_w(1 << WIN_LOG2);
  localparam logic [CNT_W-1:0]         LAST_IDX = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [SS_SYM_W-1:0]      SYM_MAX  = SS_SYM_W'(SS_SYM_MAX);

  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] win_cnt;
  logic             err;

  // The top latches sum_next/err_next on the final symbol so the result is
  // registered in the same edge that samples it (result latency of one).
  assign sum_next = sum + {{(SUM_W - SS_SYM_W){1'b0}}, sym};
  assign err_next = err | (sym > SYM_MAX);
  assign last     = enable && (win_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum     <= '0;
      win_cnt <= '0;
      err     <= 1'b0;
    end else if (enable) begin
      sum     <= sum_next;
      err     <= err_next;
      win_cnt <= win_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ss_symbol_decoder_2bit.sv
// rtl/ss_symbol_decoder_2bit.sv - window-averaging decoder for 2-bit stochastic symbols
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   begin a measurement (pulse)
//   abort         in   cancel a measurement in WARM/ACC
//   in_valid      in   ss_in is valid this cycle
//   ss_in         in   stochastic symbol, 0..2
//   busy          out  measurement in progress (WARM or ACC)
//   result_valid  out  result held for the consumer
//   result_ready  in   consumer takes the result
//   result_sum    out  sum of the 2^WIN_LOG2 window symbols
//   result_mean   out  Q2.6 mean, result_sum >> (WIN_LOG2-6)
//   sym_err       out  an illegal symbol (3) was seen in the window

module ss_symbol_decoder_2bit
  import ss_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int WARMUP   = 64,
  parameter int SUM_W    = WIN_LOG2 + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [SS_SYM_W-1:0] ss_in,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [SUM_W-1:0]    result_sum,
  output logic [7:0]          result_mean,
  output logic                sym_err
);

  if (WIN_LOG2 < MEAN_FRAC) begin : g_bad_win
    $error("WIN_LOG2 must be at least MEAN_FRAC");
  end

  localparam int               WARM_W     = ss_cnt_w(WARMUP);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam int               MEAN_SHIFT = WIN_LOG2 - MEAN_FRAC;
  localparam ss_state_t        FIRST_ST   = (WARMUP > 0) ? WARM : ACC;

  ss_state_t         state;
  logic [WARM_W-1:0] warm_cnt;

  logic              launch;
  logic              acc_en;
  logic              acc_last;
  logic [SUM_W-1:0]  acc_sum_next;
  logic              acc_err_next;

  // A new measurement starts from IDLE (abort wins over start) or straight
  // out of HOLD when the consumer accepts and restarts in the same cycle;
  // abort has no effect in HOLD.
  always_comb begin
    launch = 1'b0;
    case (state)
      IDLE:    launch = start && !abort;
      HOLD:    launch = start && result_ready;
      default: launch = 1'b0;
    endcase
  end

  // An abort in the same cycle as a window symbol discards that symbol too.
  assign acc_en = (state == ACC) && in_valid && !abort;

  ss_window_accumulator #(
    .WIN_LOG2 (WIN_LOG2),
    .SUM_W    (SUM_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (launch),
    .enable   (acc_en),
    .sym      (ss_in),
    .sum_next (acc_sum_next),
    .err_next (acc_err_next),
    .last     (acc_last)
  );

  // Result registers only change when a window completes, so an aborted
  // measurement leaves the previous result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      warm_cnt   <= '0;
      result_sum <= '0;
      sym_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state    <= FIRST_ST;
            warm_cnt <= '0;
          end
        end
        WARM: begin
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            if (warm_cnt == WARM_LAST) begin
              state <= ACC;
            end else begin
              warm_cnt <= warm_cnt + 1'b1;
            end
          end
        end
        ACC: begin
          if (abort) begin
            state <= IDLE;
          end else if (acc_last) begin
            result_sum <= acc_sum_next;
            sym_err    <= acc_err_next;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (result_ready) begin
            if (launch) begin
              state    <= FIRST_ST;
              warm_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == WARM) || (state == ACC);
  assign result_valid = (state == HOLD);
  // SUM_W is WIN_LOG2+2, so this slice is exactly the top eight bits.
  assign result_mean  = result_sum[MEAN_SHIFT +: 8];

endmodule

// File: doc/ss_symbol_decoder_2bit.md
Name: ss_symbol_decoder_2bit

Overview:
- Downstream consumer of the 2-bit stochastic-symbol stream produced by the 2-bit stochastic divider (z_output).
- Discards a configurable warm-up run of symbols while the divider's feedback counter converges, then accumulates a window of 2^WIN_LOG2 valid symbols.
- Reports the window sum and a Q2.6 mean (binary estimate of the quotient) through a valid/ready result port.

Parameters:
- WIN_LOG2, 8, log2 of window length N in valid symbols; must be >= 6.
- WARMUP, 64, number of valid symbols discarded before accumulation; 0 is legal.
- SUM_W, WIN_LOG2+2, derived width of result_sum; not overridden.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new measurement (one-cycle pulse).
- abort  in  1  cancel measurement in progress.
- in_valid  in  1  qualifies ss_in this cycle.
- ss_in  in  2  stochastic symbol; legal values 0..2.
- busy  out  1  high in WARM or ACC.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- result_sum  out  SUM_W  sum of N window symbols.
- result_mean  out  8  result_sum >> (WIN_LOG2-6), Q2.6 (0x40 = 1.0, 0x80 = 2.0).
- sym_err  out  1  a symbol value 3 was sampled in the window.

Behaviour:
- Reset: state IDLE; busy=0, result_valid=0, result_sum=0, result_mean=0, sym_err=0, all counters 0. Reset overrides every other input, including mid-measurement and mid-HOLD.
- FSM states: IDLE, WARM, ACC, HOLD.
- IDLE:
  - start & !abort -> WARM if WARMUP>0, else ACC.
  - On that transition: clear accumulator, window counter, warm-up counter and sym_err.
  - abort has priority over start.
- WARM:
  - Each in_valid increments the warm-up counter; symbols are ignored.
  - On the WARMUP-th valid symbol -> ACC next cycle.
- ACC:
  - Each in_valid adds zero-extended ss_in to the accumulator and increments the window counter.
  - A symbol value 3 is added as 3 and sets sym_err; sym_err stays set until the next start.
  - On the N-th valid symbol -> HOLD.
  - result_valid rises the cycle after that symbol is sampled (latency 1).
- HOLD:
  - result_valid=1; result_sum, result_mean and sym_err are stable.
  - result_ready -> IDLE, or directly to WARM/ACC (counters cleared) if start is also high that cycle.
  - start without result_ready is ignored; abort is ignored.
- abort in WARM or ACC: -> IDLE next cycle, no result produced. result_sum, result_mean and sym_err keep the last completed result.
- start in WARM/ACC: ignored.
- in_valid=0: all counters hold; gaps are allowed in any state.
- Width rules:
  - Accumulator is SUM_W bits, so no overflow for N symbols of value <= 3 (max 3*2^WIN_LOG2 < 2^SUM_W).
  - Window counter is WIN_LOG2+1 bits; warm-up counter is clog2(WARMUP+1) bits, minimum 1.
- result_mean is combinational from the registered result_sum; no extra latency.

Decomposition:
- Shared package ss_pkg holds:
  - state enum {IDLE, WARM, ACC, HOLD}.
  - SS_SYM_W = 2, SS_SYM_MAX = 2, MEAN_FRAC = 6.
  - a function computing counter widths from parameters.
- Sub-module ss_window_accumulator: accumulator, window counter and sym_err, with clear/enable/last outputs.
- The FSM and result handshake stay in the top level.

Test Plan:
- WIN_LOG2=8, WARMUP=4, start, then 260 consecutive valid symbols of value 1 -> result_valid the cycle after symbol 260; result_sum=256, result_mean=0x40, sym_err=0.
- Same window with symbols all 2, and in_valid low every other cycle -> result_sum=512, result_mean=0x80; busy high throughout the 520 cycles.
- Alternating 0/2 plus one value-3 symbol inside the window -> result_sum=257, sym_err=1. Symbol 3 during WARM only -> sym_err=0, sum unaffected.
- Abort after 100 ACC symbols -> IDLE next cycle, busy=0, result_valid stays 0, previous result outputs unchanged. Start+abort in IDLE -> stays IDLE.
- Back-pressure: hold result_ready=0 for 20 cycles -> outputs stable, start ignored. Then result_ready=1 with start=1 -> next cycle in WARM with counters cleared.
- rst asserted mid-ACC and again during HOLD -> next cycle all outputs 0, state IDLE; a fresh start afterwards yields a correct sum.
